// File: rtl/pal_term_programmer_pkg.sv
// Shared definitions for the PAL AND-term programmer: FSM encoding and width helpers.
// Define PAL_PARITY_EN to add an even-parity bit as the MSB of each config word.
package pal_term_programmer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

`ifdef PAL_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pal_term_programmer_wen_decoder.sv
// Registered one-hot write-strobe decoder: term_wen[idx] is set while en is high.
module pal_term_programmer_wen_decoder #(
  parameter int NUM_TERMS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IDX_W-1:0]     idx,
  output logic [NUM_TERMS-1:0] term_wen
);

  logic [NUM_TERMS-1:0] wen_n;

  always_comb begin
    wen_n = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      wen_n[i] = en && (idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) term_wen <= '0;
    else     term_wen <= wen_n;
  end

endmodule

// File: rtl/pal_term_programmer.sv
// Write-side controller that streams one select mask per PAL AND term and strobes it in.
// Optional parity checking of config words is enabled with PAL_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet, term_sel keeps last mask
// FETCH  | cfg_ready high, waiting for the next term mask
// SETUP  | term_sel driven, strobe low (setup margin)
// STROBE | term_wen[idx] high for STROBE_CYCLES cycles
// HOLD   | strobe low, term_sel unchanged (hold margin)
// DONE   | one-cycle done pulse, then back to IDLE
module pal_term_programmer
  import pal_term_programmer_pkg::*;
#(
  parameter int NUM_INPUTS    = 5,
  parameter int NUM_TERMS     = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_INPUTS+PAR_W-1:0] cfg_data,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic [NUM_INPUTS-1:0]       term_sel,
  output logic [NUM_TERMS-1:0]        term_wen,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int IDX_W = idx_width(NUM_TERMS);
  localparam int CNT_W = idx_width(STROBE_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_TERMS - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             parity_bad;

  assign accept = (state == ST_FETCH) && cfg_valid && cfg_ready;

`ifdef PAL_PARITY_EN
  // Even parity: mask bits plus parity bit must XOR to zero.
  assign parity_bad = ^cfg_data;
`else
  assign parity_bad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    if (abort && (state != ST_IDLE)) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start && !abort) state_n = ST_FETCH;
        ST_FETCH:  if (accept) state_n = parity_bad ? ST_IDLE : ST_SETUP;
        ST_SETUP:  state_n = ST_STROBE;
        ST_STROBE: if (cnt == '0) state_n = ST_HOLD;
        ST_HOLD:   state_n = (idx == LAST_IDX) ? ST_DONE : ST_FETCH;
        ST_DONE:   state_n = ST_IDLE;
        default:   state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      term_sel  <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cfg_ready <= (state_n == ST_FETCH);
      busy      <= state_n inside {ST_FETCH, ST_SETUP, ST_STROBE, ST_HOLD};
      done      <= (state_n == ST_DONE);

      if ((state == ST_IDLE) && (state_n == ST_FETCH)) begin
        idx <= '0;
        err <= 1'b0;
      end else if ((state == ST_HOLD) && (state_n == ST_FETCH)) begin
        idx <= idx + 1'b1;
      end

      if ((state_n == ST_STROBE) && (state != ST_STROBE)) cnt <= STROBE_LOAD;
      else if ((state == ST_STROBE) && (cnt != '0))       cnt <= cnt - 1'b1;

      // A word accepted alongside abort is consumed but never reaches a strobe.
      if (accept && !parity_bad)          term_sel <= cfg_data[NUM_INPUTS-1:0];
      if (accept && parity_bad && !abort) err      <= 1'b1;
    end
  end

  pal_term_programmer_wen_decoder #(
    .NUM_TERMS (NUM_TERMS),
    .IDX_W     (IDX_W)
  ) u_wen_decoder (
    .clk      (clk),
    .rst      (rst),
    .en       (state_n == ST_STROBE),
    .idx      (idx),
    .term_wen (term_wen)
  );

endmodule

// File: tb/tb_pal_term_programmer.sv
// Self-checking bench for pal_term_programmer: models the PAL term array and pass timing.
module tb_pal_term_programmer;

  localparam int NI = 5;
  localparam int NT = 4;
  localparam int S  = 2;
`ifdef PAL_PARITY_EN
  localparam int CW = NI + 1;
`else
  localparam int CW = NI;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [NI-1:0] term_sel;
  logic [NT-1:0] term_wen;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;

  // Model of the external PAL terms: each latches term_sel on its strobe's rising edge.
  logic [NI-1:0] pal_mem [NT];
  int            strobe_cnt [NT];
  int            exp_idx;
  int            done_cnt;
  int            pulse_len;
  bit            abort_window;
  logic [NT-1:0] prev_wen = '0;
  logic [NI-1:0] prev_sel = '0;
  logic [NI-1:0] latched_sel = '0;

  pal_term_programmer #(
    .NUM_INPUTS    (NI),
    .NUM_TERMS     (NT),
    .STROBE_CYCLES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .term_sel  (term_sel),
    .term_wen  (term_wen),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] enc(input logic [NI-1:0] m);
`ifdef PAL_PARITY_EN
    return {^m, m};
`else
    return m;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(term_wen) > 1) chk("wen_onehot", 32'(term_wen), 32'(prev_wen));
      if (term_wen != '0) chk("wen_busy", 32'(busy), 32'd1);
      for (int i = 0; i < NT; i++) begin
        if (term_wen[i] && !prev_wen[i]) begin
          chk("strobe_idx", i, exp_idx);
          chk("setup_sel", 32'(prev_sel), 32'(term_sel));
          pal_mem[i]    = term_sel;
          latched_sel   = term_sel;
          strobe_cnt[i] = strobe_cnt[i] + 1;
          exp_idx       = exp_idx + 1;
          pulse_len     = 0;
        end
      end
      if (term_wen != '0) pulse_len = pulse_len + 1;
      if ((prev_wen != '0) && (term_wen == '0) && !abort_window) begin
        chk("strobe_len", pulse_len, S);
        chk("hold_sel", 32'(term_sel), 32'(latched_sel));
      end
      if (done) done_cnt = done_cnt + 1;
    end
    prev_wen = term_wen;
    prev_sel = term_sel;
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: normal pass; 1: abort during strobe of term k; 2: rst in SETUP of term k;
  // 3: abort in the same cycle as the handshake of term k.
  task automatic run_pass(input logic [NI-1:0] m [NT], input int stalls [NT],
                          input bit noise, input int mode, input int k);
    logic [NI-1:0] old_mem [NT];
    int  cyc, term, stall_left, exp_cyc;
    bit  finished, rdy_before, got_accept, in_setup, event_hit;
    for (int i = 0; i < NT; i++) begin
      old_mem[i]    = pal_mem[i];
      strobe_cnt[i] = 0;
    end
    abort_window = 1'b0;
    exp_idx      = 0;
    done_cnt     = 0;
    exp_cyc      = NT * (S + 3);
    for (int i = 0; i < NT; i++) exp_cyc += stalls[i];

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(cfg_ready), 32'd1);
    chk("start_err", 32'(err), 32'd0);

    cyc        = 0;
    term       = 0;
    stall_left = stalls[0];
    finished   = 1'b0;
    in_setup   = 1'b0;
    event_hit  = 1'b0;
    while (!finished && cyc < 400) begin
      start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      rdy_before = cfg_ready;
      cfg_valid  = rdy_before && (stall_left == 0) && (term < NT);
      cfg_data   = enc(m[(term < NT) ? term : 0]);
      abort      = 1'b0;
      if (mode == 1 && term_wen[k]) abort = 1'b1;
      if (mode == 3 && term == k && cfg_valid) abort = 1'b1;
      if (mode == 2 && in_setup) rst = 1'b1;
      if (abort || rst) begin
        event_hit    = 1'b1;
        abort_window = 1'b1;
      end
      got_accept = cfg_valid && rdy_before;
      @(posedge clk);
      #1;
      cyc++;
      in_setup = 1'b0;
      if (event_hit) begin
        finished = 1'b1;
      end else begin
        if (got_accept) begin
          if (term == k) in_setup = 1'b1;
          term++;
          stall_left = (term < NT) ? stalls[term] : 0;
        end else if (rdy_before && stall_left > 0) begin
          stall_left--;
        end
        if (done) finished = 1'b1;
      end
    end
    start     = 1'b0;
    cfg_valid = 1'b0;

    if (mode == 0) begin
      chk("pass_done", 32'(done), 32'd1);
      chk("pass_cycles", cyc, exp_cyc);
      chk("done_busy", 32'(busy), 32'd0);
      chk("final_sel", 32'(term_sel), 32'(m[NT-1]));
      idle_cycles(1);
      chk("post_done", 32'(done), 32'd0);
      chk("post_ready", 32'(cfg_ready), 32'd0);
      chk("done_count", done_cnt, 1);
      for (int i = 0; i < NT; i++) begin
        chk("pal_mem", 32'(pal_mem[i]), 32'(m[i]));
        chk("strobe_count", strobe_cnt[i], 1);
      end
    end else begin
      chk("evt_hit", 32'(event_hit), 32'd1);
      chk("evt_wen", 32'(term_wen), 32'd0);
      chk("evt_busy", 32'(busy), 32'd0);
      chk("evt_ready", 32'(cfg_ready), 32'd0);
      chk("evt_done", 32'(done), 32'd0);
      if (mode == 2) begin
        chk("rst_sel", 32'(term_sel), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
      end
      abort = 1'b0;
      rst   = 1'b0;
      idle_cycles(6);
      chk("evt_no_done", done_cnt, 0);
      chk("evt_idle_busy", 32'(busy), 32'd0);
      for (int i = 0; i < NT; i++) begin
        if (i < k || (mode == 1 && i == k)) begin
          chk("evt_mem_new", 32'(pal_mem[i]), 32'(m[i]));
          chk("evt_strobes", strobe_cnt[i], 1);
        end else begin
          chk("evt_mem_old", 32'(pal_mem[i]), 32'(old_mem[i]));
          chk("evt_strobes", strobe_cnt[i], 0);
        end
      end
    end
  endtask

  logic [NI-1:0] masks [NT];
  int            stalls [NT];

  initial begin
    for (int i = 0; i < NT; i++) begin
      pal_mem[i]    = '0;
      strobe_cnt[i] = 0;
    end
    exp_idx = 0; done_cnt = 0; pulse_len = 0; abort_window = 1'b0;

    idle_cycles(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err0", 32'(err), 32'd0);
    chk("rst_ready0", 32'(cfg_ready), 32'd0);
    chk("rst_wen0", 32'(term_wen), 32'd0);
    chk("rst_sel0", 32'(term_sel), 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Directed back-to-back pass.
    masks  = '{5'h03, 5'h1F, 5'h00, 5'h15};
    stalls = '{0, 0, 0, 0};
    run_pass(masks, stalls, 1'b0, 0, 0);

    // Ten-cycle backpressure during the FETCH of term 2.
    masks  = '{5'h0A, 5'h11, 5'h1C, 5'h07};
    stalls = '{0, 0, 10, 0};
    run_pass(masks, stalls, 1'b0, 0, 0);

    // Randomised passes with stalls and start pulses while busy.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < NT; i++) begin
        masks[i]  = NI'($urandom);
        stalls[i] = $urandom_range(0, 3);
      end
      run_pass(masks, stalls, 1'b1, 0, 0);
    end

    // Abort during the strobe of term 1, then a fresh pass from index 0.
    masks  = '{5'h19, 5'h06, 5'h13, 5'h0C};
    stalls = '{0, 1, 0, 0};
    run_pass(masks, stalls, 1'b0, 1, 1);
    for (int i = 0; i < NT; i++) masks[i] = NI'($urandom);
    stalls = '{0, 0, 0, 0};
    run_pass(masks, stalls, 1'b1, 0, 0);

    // Reset while term 2 is in SETUP.
    masks  = '{5'h01, 5'h02, 5'h04, 5'h08};
    run_pass(masks, stalls, 1'b0, 2, 2);

    // Abort coincident with the handshake of term 1.
    masks  = '{5'h1E, 5'h1D, 5'h1B, 5'h17};
    run_pass(masks, stalls, 1'b0, 3, 1);

    // start with abort in IDLE is ignored.
    start = 1'b1;
    abort = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_ready", 32'(cfg_ready), 32'd0);
    idle_cycles(1);
    chk("idle_abort_busy2", 32'(busy), 32'd0);

`ifdef PAL_PARITY_EN
    // Bad parity word: err set, nothing strobed, pass abandoned.
    for (int i = 0; i < NT; i++) strobe_cnt[i] = 0;
    done_cnt = 0;
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    cfg_data  = {1'b1, 5'h03};
    cfg_valid = 1'b1;
    idle_cycles(1);
    cfg_valid = 1'b0;
    chk("par_err", 32'(err), 32'd1);
    chk("par_busy", 32'(busy), 32'd0);
    chk("par_wen", 32'(term_wen), 32'd0);
    idle_cycles(4);
    chk("par_err_sticky", 32'(err), 32'd1);
    chk("par_no_strobe", strobe_cnt[0], 0);
    chk("par_no_done", done_cnt, 0);
    masks = '{5'h03, 5'h05, 5'h09, 5'h11};
    run_pass(masks, stalls, 1'b0, 0, 0);
    chk("par_err_clear", 32'(err), 32'd0);
`else
    chk("err_tied", 32'(err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
